pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage MIPS pipeline.
- Sits beside the main Control decoder and generates every pipeline-register write enable and flush:
  - load-use stalls
  - branch/jump flushes
  - full-pipeline freeze while the data memory holds off its ready handshake
- Keeps a wait-timeout flag and a stall-cycle performance counter.

Parameters:
- REG_W, 5, register-specifier width.
- TIMEOUT, 64, consecutive frozen cycles before memTimeout sets (≥2).
- CNT_W, 16, stallCount width.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- idRs  in  REG_W  rs of the instruction in ID.
- idRt  in  REG_W  rt of the instruction in ID.
- idUseRs  in  1  ID instruction reads rs.
- idUseRt  in  1  ID instruction reads rt.
- idJump  in  1  jump decoded in ID.
- exMemRead  in  1  ID/EX holds a load.
- exRegWrite  in  1  ID/EX instruction writes a register.
- exRd  in  REG_W  destination of the ID/EX instruction.
- exBranchTaken  in  1  branch resolved taken in EX.
- dmemReq  in  1  MEM stage is accessing data memory.
- dmemReady  in  1  data memory completes the access this cycle.
- pcWrite  out  1  PC update enable.
- ifIdWrite  out  1  IF/ID write enable.
- ifIdFlush  out  1  IF/ID loads a NOP.
- idExFlush  out  1  ID/EX loads a bubble (all control zero).
- freeze  out  1  EX/MEM and MEM/WB hold; also implies pcWrite=ifIdWrite=0.
- memTimeout  out  1  sticky: memory wait exceeded TIMEOUT.
- stallCount  out  CNT_W  saturating count of cycles with pcWrite=0.

Behaviour:
- State register, two states:
  - RUN: no memory wait in progress.
  - MEM_WAIT: a data access is outstanding.
- Reset (rstN=0, async):
  - state=RUN, waitCnt=0, memTimeout=0, stallCount=0.
  - Outputs forced: pcWrite=0, ifIdWrite=0, ifIdFlush=0, idExFlush=0, freeze=0.
- All enables and flushes are combinational from the current state and inputs, so they take effect on the same edge.
- Freeze condition: freeze = dmemReq & ~dmemReady in RUN, or ~dmemReady in MEM_WAIT.
- FSM transitions:
  - RUN→MEM_WAIT when dmemReq & ~dmemReady.
  - MEM_WAIT→RUN on the cycle dmemReady=1. That cycle is not frozen.
  - Zero-wait memory (dmemReady with dmemReq) never leaves RUN.
- Load-use condition: exMemRead & exRegWrite & exRd≠0 & ((idUseRs & idRs==exRd) | (idUseRt & idRt==exRd)).
- Output priority, highest first:
  1. freeze: pcWrite=0, ifIdWrite=0, ifIdFlush=0, idExFlush=0. Branch, jump and load-use are deferred because all stage registers hold.
  2. exBranchTaken: pcWrite=1, ifIdWrite=1, ifIdFlush=1, idExFlush=1. This overrides load-use, since the dependent instruction is squashed.
  3. load-use: pcWrite=0, ifIdWrite=0, idExFlush=1, ifIdFlush=0. Exactly one bubble per hazard; the next cycle the load is in MEM and the condition is false. A jump in ID is re-evaluated after the stall.
  4. idJump: pcWrite=1, ifIdWrite=1, ifIdFlush=1, idExFlush=0.
  5. otherwise: pcWrite=1, ifIdWrite=1, no flushes.
- waitCnt:
  - Increments each frozen cycle; clears on any unfrozen cycle.
  - Saturates at TIMEOUT.
  - memTimeout sets on the edge where waitCnt reaches TIMEOUT (TIMEOUT consecutive frozen cycles). Cleared only by reset; the pipeline keeps waiting.
- stallCount increments every post-reset cycle with pcWrite=0 and saturates at all-ones.
- Reset asserted mid-MEM_WAIT returns to RUN immediately; the outstanding access is abandoned.

Test Plan:
- Load-use: exMemRead=1, exRegWrite=1, exRd=5, idUseRs=1, idRs=5 for one cycle → that cycle pcWrite=0, ifIdWrite=0, idExFlush=1; next cycle (inputs cleared) pcWrite=1; stallCount=1. Repeat with exRd=0 → no stall.
- Branch vs load-use: exBranchTaken=1 together with a load-use match → pcWrite=1, ifIdFlush=1, idExFlush=1; stallCount unchanged.
- Jump: idJump=1 alone → ifIdFlush=1, idExFlush=0, pcWrite=1.
- Memory wait: dmemReq=1, dmemReady=0 for 3 cycles, then ready=1 → freeze=1 for exactly 3 cycles, 0 on the ready cycle, state back in RUN; a concurrent exBranchTaken produces no flush until freeze drops; stallCount=3.
- Timeout: TIMEOUT=4, hold dmemReq=1 and dmemReady=0 for 6 cycles → memTimeout rises after 4 frozen cycles and stays 1 after ready; only rstN=0 clears it.
- Async reset mid-wait: drop rstN during MEM_WAIT between clock edges → outputs go to their reset values immediately; after release with dmemReq=0, pcWrite=1 on the first cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Purpose  : Bundles the ID/EX/MEM hazard inputs and the pipeline-register
//             enables/flushes exchanged with pipeline_hazard_ctrl.
//  Modports : master - pipeline datapath (drives hazard info, takes enables)
//             slave  - hazard controller (takes hazard info, drives enables)
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  // Hazard information from the datapath
  logic [REG_W-1:0] idRs;
  logic [REG_W-1:0] idRt;
  logic             idUseRs;
  logic             idUseRt;
  logic             idJump;
  logic             exMemRead;
  logic             exRegWrite;
  logic [REG_W-1:0] exRd;
  logic             exBranchTaken;
  logic             dmemReq;
  logic             dmemReady;

  // Enables, flushes and status back to the datapath
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             freeze;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output idRs, idRt, idUseRs, idUseRt, idJump, exMemRead, exRegWrite,
           exRd, exBranchTaken, dmemReq, dmemReady,
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, freeze, memTimeout,
           stallCount
  );

  modport slave (
    input  idRs, idRt, idUseRs, idUseRt, idJump, exMemRead, exRegWrite,
           exRd, exBranchTaken, dmemReq, dmemReady,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, freeze, memTimeout,
           stallCount
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard and stall sequencer for the 5-stage MIPS pipeline.
//             Produces PC / IF-ID write enables and IF-ID / ID-EX flushes for
//             load-use stalls and branch/jump redirects, freezes the whole
//             pipeline while data memory withholds ready, flags an overlong
//             memory wait and counts stalled cycles.
//  Ports    : clk   - clock, rising edge
//             rstN  - asynchronous active-low reset
//             bus   - pipeline_hazard_ctrl_if.slave (hazard inputs in,
//                     pcWrite/ifIdWrite/ifIdFlush/idExFlush/freeze/
//                     memTimeout/stallCount out)
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  wire logic            clk,
  input  wire logic            rstN,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int                  c_WAIT_W       = $clog2(TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT      = c_WAIT_W'(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT_LAST = c_WAIT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_WAIT_W-1:0] r_waitCnt;
  logic                r_memTimeout;
  logic [CNT_W-1:0]    r_stallCount;

  logic [REG_W-1:0] w_idRs;
  logic [REG_W-1:0] w_idRt;
  logic [REG_W-1:0] w_exRd;
  logic             w_freeze;
  logic             w_loadUse;
  logic             w_pcWrite;
  logic             w_ifIdWrite;
  logic             w_ifIdFlush;
  logic             w_idExFlush;

  assign w_idRs = bus.idRs;
  assign w_idRt = bus.idRt;
  assign w_exRd = bus.exRd;

  // In MEM_WAIT the access is already in flight, so only ready matters.
  assign w_freeze = (r_state == MEM_WAIT) ? ~bus.dmemReady
                                          : (bus.dmemReq & ~bus.dmemReady);

  // Writes to $zero never create a dependency.
  assign w_loadUse = bus.exMemRead & bus.exRegWrite & (w_exRd != {REG_W{1'b0}}) &
                     ((bus.idUseRs & (w_idRs == w_exRd)) |
                      (bus.idUseRt & (w_idRt == w_exRd)));

  always_comb begin
    w_pcWrite   = 1'b1;
    w_ifIdWrite = 1'b1;
    w_ifIdFlush = 1'b0;
    w_idExFlush = 1'b0;
    if (w_freeze) begin
      // Every stage register holds; redirects are taken once memory answers.
      w_pcWrite   = 1'b0;
      w_ifIdWrite = 1'b0;
    end else if (bus.exBranchTaken) begin
      // The dependent instruction is squashed, so load-use no longer matters.
      w_ifIdFlush = 1'b1;
      w_idExFlush = 1'b1;
    end else if (w_loadUse) begin
      w_pcWrite   = 1'b0;
      w_ifIdWrite = 1'b0;
      w_idExFlush = 1'b1;
    end else if (bus.idJump) begin
      w_ifIdFlush = 1'b1;
    end
  end

  // Combinational enables are masked while reset is asserted so they read
  // as their reset values immediately, without waiting for a clock.
  assign bus.pcWrite    = rstN & w_pcWrite;
  assign bus.ifIdWrite  = rstN & w_ifIdWrite;
  assign bus.ifIdFlush  = rstN & w_ifIdFlush;
  assign bus.idExFlush  = rstN & w_idExFlush;
  assign bus.freeze     = rstN & w_freeze;
  assign bus.memTimeout = r_memTimeout;
  assign bus.stallCount = r_stallCount;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
      r_stallCount <= '0;
    end else begin
      case (r_state)
        RUN:      if (bus.dmemReq & ~bus.dmemReady) r_state <= MEM_WAIT;
        MEM_WAIT: if (bus.dmemReady)                r_state <= RUN;
        default:                                    r_state <= RUN;
      endcase

      if (w_freeze) begin
        if (r_waitCnt != c_TIMEOUT) begin
          r_waitCnt <= r_waitCnt + 1'b1;
        end
        // Sets on the edge that brings the count to TIMEOUT; sticky after.
        if (r_waitCnt >= c_TIMEOUT_LAST) begin
          r_memTimeout <= 1'b1;
        end
      end else begin
        r_waitCnt <= '0;
      end

      if (!w_pcWrite && (r_stallCount != {CNT_W{1'b1}})) begin
        r_stallCount <= r_stallCount + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl: directed scenarios
//             followed by random hazard traffic, compared every cycle against
//             a behavioural model of the stall/flush rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int c_REG_W   = 5;
  localparam int c_TIMEOUT = 4;
  localparam int c_CNT_W   = 16;

  logic clk;
  logic rstN;

  pipeline_hazard_ctrl_if #(.REG_W(c_REG_W), .CNT_W(c_CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .REG_W  (c_REG_W),
    .TIMEOUT(c_TIMEOUT),
    .CNT_W  (c_CNT_W)
  ) u_dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Model: an access is outstanding exactly when the previous cycle froze.
  bit mWaiting;
  int mWaitRun;
  bit mTimeout;
  int mStalls;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mWaiting = 1'b0;
    mWaitRun = 0;
    mTimeout = 1'b0;
    mStalls  = 0;
  endtask

  task automatic driveIdle();
    bus.idRs = '0; bus.idRt = '0; bus.idUseRs = 1'b0; bus.idUseRt = 1'b0;
    bus.idJump = 1'b0; bus.exMemRead = 1'b0; bus.exRegWrite = 1'b0;
    bus.exRd = '0; bus.exBranchTaken = 1'b0; bus.dmemReq = 1'b0; bus.dmemReady = 1'b0;
  endtask

  // Called at a falling edge: apply inputs, check, advance model one cycle.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic jmp, input logic mr, input logic rw,
                      input logic [4:0] rd, input logic br, input logic req, input logic rdy);
    bit frz, lu;
    bit ePc, eIfw, eIff, eIef;
    bus.idRs = rs; bus.idRt = rt; bus.idUseRs = urs; bus.idUseRt = urt;
    bus.idJump = jmp; bus.exMemRead = mr; bus.exRegWrite = rw; bus.exRd = rd;
    bus.exBranchTaken = br; bus.dmemReq = req; bus.dmemReady = rdy;
    #1;
    frz = mWaiting ? !rdy : (req && !rdy);
    lu  = mr && rw && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    if (frz)      begin ePc = 0; eIfw = 0; eIff = 0; eIef = 0; end
    else if (br)  begin ePc = 1; eIfw = 1; eIff = 1; eIef = 1; end
    else if (lu)  begin ePc = 0; eIfw = 0; eIff = 0; eIef = 1; end
    else if (jmp) begin ePc = 1; eIfw = 1; eIff = 1; eIef = 0; end
    else          begin ePc = 1; eIfw = 1; eIff = 0; eIef = 0; end
    checkVal("pcWrite",    32'(bus.pcWrite),    32'(ePc));
    checkVal("ifIdWrite",  32'(bus.ifIdWrite),  32'(eIfw));
    checkVal("ifIdFlush",  32'(bus.ifIdFlush),  32'(eIff));
    checkVal("idExFlush",  32'(bus.idExFlush),  32'(eIef));
    checkVal("freeze",     32'(bus.freeze),     32'(frz));
    checkVal("memTimeout", 32'(bus.memTimeout), 32'(mTimeout));
    checkVal("stallCount", 32'(bus.stallCount), 32'(mStalls));
    mWaiting = frz;
    mWaitRun = frz ? ((mWaitRun + 1 > c_TIMEOUT) ? c_TIMEOUT : mWaitRun + 1) : 0;
    if (mWaitRun == c_TIMEOUT) mTimeout = 1'b1;
    if (!ePc && mStalls < 65535) mStalls++;
    @(negedge clk);
  endtask

  task automatic stepIdle();
    step(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic stepMem(input logic br, input logic req, input logic rdy);
    step(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, br, req, rdy);
  endtask

  // Called at a falling edge; returns at a later falling edge, out of reset.
  task automatic doReset();
    driveIdle();
    rstN = 1'b0;
    #1;
    checkVal("rst_pcWrite",    32'(bus.pcWrite),    32'd0);
    checkVal("rst_stallCount", 32'(bus.stallCount), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  initial begin
    rstN = 1'b0;
    driveIdle();
    modelReset();
    #2;
    checkVal("reset_pcWrite",    32'(bus.pcWrite),    32'd0);
    checkVal("reset_ifIdWrite",  32'(bus.ifIdWrite),  32'd0);
    checkVal("reset_freeze",     32'(bus.freeze),     32'd0);
    checkVal("reset_memTimeout", 32'(bus.memTimeout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    // Load-use on rs, then cleared inputs, then same with exRd = 0
    step(5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0, 0, 0);
    stepIdle();
    checkVal("lu_stallCount", 32'(bus.stallCount), 32'd1);
    step(5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 0, 0, 0);
    // Load-use through rt only
    step(5'd1, 5'd9, 1, 1, 0, 1, 1, 5'd9, 0, 0, 0);

    // Branch overrides load-use
    doReset();
    step(5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 1, 0, 0);
    checkVal("br_stallCount", 32'(bus.stallCount), 32'd0);

    // Jump alone, and jump under a load-use stall
    step(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 0, 0);
    step(5'd3, 5'd0, 1, 0, 1, 1, 1, 5'd3, 0, 0, 0);

    // Memory wait of three cycles with a pending branch
    doReset();
    stepMem(1, 1, 0);
    stepMem(1, 1, 0);
    stepMem(1, 1, 0);
    stepMem(1, 1, 1);
    stepIdle();
    checkVal("wait_stallCount", 32'(bus.stallCount), 32'd3);
    // Zero-wait access stays in RUN
    stepMem(0, 1, 1);
    stepMem(0, 0, 0);

    // Timeout after TIMEOUT frozen cycles, sticky past ready
    doReset();
    for (int i = 0; i < 6; i++) stepMem(0, 1, 0);
    stepMem(0, 1, 1);
    stepIdle();
    checkVal("to_sticky", 32'(bus.memTimeout), 32'd1);
    doReset();
    checkVal("to_cleared", 32'(bus.memTimeout), 32'd0);

    // Asynchronous reset between edges while waiting
    stepMem(0, 1, 0);
    stepMem(0, 1, 0);
    #2;
    rstN = 1'b0;
    #1;
    checkVal("async_freeze",     32'(bus.freeze),     32'd0);
    checkVal("async_pcWrite",    32'(bus.pcWrite),    32'd0);
    checkVal("async_stallCount", 32'(bus.stallCount), 32'd0);
    driveIdle();
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    stepIdle();

    // Random traffic
    doReset();
    for (int i = 0; i < 600; i++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
